stopwatch_ctrl: RTL and testbench
=================================

// Module: stopwatch_ctrl
// PURPOSE
//  Control FSM that sequences the stopwatch BCD counter datapath.
//  Debounces the start/stop/lap/clear buttons and generates the 100 Hz count tick.
//  Drives increment/clear strobes to the external bcd16 counter.
//  Selects the live or lap-frozen value for the two seven-segment controllers.
// PARAMETERS
//  TICK_DIV         120000  CLK cycles per count tick (12 MHz -> 100 Hz)
//  DEBOUNCE_CYCLES  120000  consecutive stable cycles before a button level is accepted
// PORTS
//  CLK         in   1   system clock, 12 MHz
//  RST         in   1   asynchronous, active-high reset
//  BTN_START   in   1   raw button, active high, asynchronous to CLK
//  BTN_STOP    in   1   raw button, active high
//  BTN_LAP     in   1   raw button, active high
//  BTN_CLEAR   in   1   raw button, active high
//  cnt_value   in   16  current BCD count (4 digits) from the counter
//  cnt_inc     out  1   one-cycle increment strobe to the counter
//  cnt_clr     out  1   one-cycle synchronous clear strobe to the counter
//  disp_value  out  16  BCD value to the display controllers
//  running     out  1   high in RUN or LAP
//  lap_active  out  1   high in LAP
//  overflow    out  1   sticky: count saturated at 9999
// BEHAVIOUR
//  Reset: state=IDLE; prescaler=0; lap_reg=0; all outputs 0; debounced levels 0.
//  Buttons: 2-FF synchroniser, then debounce. The debounced level flips only after
//   DEBOUNCE_CYCLES consecutive cycles of differing synced input. A press event is a
//   1-cycle pulse on the debounced 0->1 edge. Release generates no event.
//  Same-cycle events resolve by priority CLEAR > STOP > LAP > START. Only the winner acts.
//  States and transitions:
//   IDLE : START -> RUN, prescaler:=0.
//   RUN  : STOP -> PAUSE. LAP -> LAP, lap_reg:=cnt_value. START is ignored.
//   LAP  : LAP -> RUN (display live again). STOP -> PAUSE (display live). START is ignored.
//   PAUSE: START -> RUN. The prescaler keeps its residue. LAP is ignored.
//   any  : CLEAR -> IDLE, cnt_clr=1 next cycle, prescaler:=0, overflow:=0, lap_reg:=0.
//  Prescaler:
//   Counts only in RUN/LAP; wraps at TICK_DIV-1 and raises tick for that cycle.
//  Increment:
//   On tick, if cnt_value!=16'h9999, cnt_inc=1 on the next cycle.
//   On tick with cnt_value==16'h9999: no inc, state -> PAUSE, overflow:=1.
//   START from PAUSE while overflow=1 is ignored; only CLEAR recovers.
//  A tick in the same cycle as STOP is dropped. STOP wins and no inc is issued.
//  cnt_inc and cnt_clr are registered, never both high, and never high for 2 cycles.
//  disp_value: registered, 1-cycle latency. lap_reg in LAP, else cnt_value.
//  RST mid-operation: everything returns to reset values immediately. cnt_clr is not
//   pulsed; the counter has its own reset.
// STRUCTURE
//  Shared include stopwatch_defs.vh: state encodings (IDLE/RUN/LAP/PAUSE),
//   BCD_MAX=16'h9999, and the priority ordering of button events.
//  Sub-module button_debounce (sync + stable counter + edge pulse), instantiated 4x.
//  Top-level module: FSM, prescaler, lap register, output registers.
// TESTING (TICK_DIV=4, DEBOUNCE_CYCLES=3, behavioural bcd16 counter attached)
//  1. BTN_START glitch of 2 cycles -> no event, state IDLE, cnt_inc stays 0.
//  2. START held 10 cycles -> RUN, then cnt_inc every 4 cycles; count reaches 0x0005 after 5 ticks.
//  3. In RUN at 0x0012, press LAP -> disp_value holds 0x0012 while cnt_value
//     advances; press LAP again -> disp_value tracks live again.
//  4. STOP and LAP pressed in the same cycle in RUN -> PAUSE, lap_active=0, no inc
//     afterwards; START -> RUN, first inc after the remaining prescaler residue.
//  5. Preload 0x9998 and run -> one inc to 0x9999, then state PAUSE, overflow=1.
//     START is ignored; CLEAR gives cnt_clr pulse, IDLE, overflow=0.
//  6. Assert RST during LAP -> all outputs 0 asynchronously; after release, state
//     IDLE and no strobes until START.

Source files
------------

// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch controller: FSM states, button indices,
// the BCD saturation value and the same-cycle button priority resolver.
package stopwatch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_LAP   = 2'd2,
        ST_PAUSE = 2'd3
    } sw_state_e;

    typedef enum logic [2:0] {
        EV_NONE  = 3'd0,
        EV_START = 3'd1,
        EV_LAP   = 3'd2,
        EV_STOP  = 3'd3,
        EV_CLEAR = 3'd4
    } btn_event_e;

    localparam logic [15:0] BCD_MAX = 16'h9999;

    localparam int unsigned NUM_BTNS      = 4;
    localparam int unsigned BTN_START_IDX = 0;
    localparam int unsigned BTN_LAP_IDX   = 1;
    localparam int unsigned BTN_STOP_IDX  = 2;
    localparam int unsigned BTN_CLEAR_IDX = 3;

    // Only one press acts per cycle: CLEAR > STOP > LAP > START.
    function automatic btn_event_e resolve_event(input logic [NUM_BTNS-1:0] press);
        if (press[BTN_CLEAR_IDX]) return EV_CLEAR;
        if (press[BTN_STOP_IDX])  return EV_STOP;
        if (press[BTN_LAP_IDX])   return EV_LAP;
        if (press[BTN_START_IDX]) return EV_START;
        return EV_NONE;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser, stable-level debouncer and one-cycle press pulse
// generated on the accepted 0->1 transition.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 120000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic press_o
);
    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [1:0]    sync_q;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q  <= 2'b00;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    // Any cycle where the synced input matches the accepted level restarts the count.
    always_comb begin
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync_q[1];
                press_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing FSM: button handling, count-tick prescaler, lap freeze
// register and registered strobes/display value for the external BCD counter.
module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV        = 120000,
    parameter int unsigned DEBOUNCE_CYCLES = 120000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        BTN_START,
    input  logic        BTN_STOP,
    input  logic        BTN_LAP,
    input  logic        BTN_CLEAR,
    input  logic [15:0] cnt_value,
    output logic        cnt_inc,
    output logic        cnt_clr,
    output logic [15:0] disp_value,
    output logic        running,
    output logic        lap_active,
    output logic        overflow
);
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [NUM_BTNS-1:0] btn_raw;
    logic [NUM_BTNS-1:0] btn_press;
    btn_event_e          ev;

    sw_state_e   state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [15:0] lap_q, lap_d;
    logic [15:0] disp_q, disp_d;
    logic        ovf_q, ovf_d;
    logic        inc_q, inc_d;
    logic        clr_q, clr_d;
    logic        counting;
    logic        tick;

    assign btn_raw[BTN_START_IDX] = BTN_START;
    assign btn_raw[BTN_LAP_IDX]   = BTN_LAP;
    assign btn_raw[BTN_STOP_IDX]  = BTN_STOP;
    assign btn_raw[BTN_CLEAR_IDX] = BTN_CLEAR;

    generate
        for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
            button_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk_i  (CLK),
                .rst_i  (RST),
                .btn_i  (btn_raw[gi]),
                .press_o(btn_press[gi])
            );
        end
    endgenerate

    assign ev       = resolve_event(btn_press);
    assign counting = (state_q == ST_RUN) || (state_q == ST_LAP);
    assign tick     = counting && (pre_q == PW'(TICK_DIV - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Saturation at 9999 parks the watch in PAUSE, but an explicit STOP still wins.
    always_comb begin
        state_d = state_q;
        if (ev == EV_CLEAR) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (ev == EV_START) state_d = ST_RUN;
                ST_RUN, ST_LAP: begin
                    if (ev == EV_STOP) begin
                        state_d = ST_PAUSE;
                    end else if (tick && (cnt_value == BCD_MAX)) begin
                        state_d = ST_PAUSE;
                    end else if (ev == EV_LAP) begin
                        state_d = (state_q == ST_RUN) ? ST_LAP : ST_RUN;
                    end
                end
                ST_PAUSE: if ((ev == EV_START) && !ovf_q) state_d = ST_RUN;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        inc_d  = 1'b0;
        clr_d  = 1'b0;
        pre_d  = pre_q;
        lap_d  = lap_q;
        ovf_d  = ovf_q;
        disp_d = (state_q == ST_LAP) ? lap_q : cnt_value;
        if (ev == EV_CLEAR) begin
            clr_d = 1'b1;
            pre_d = '0;
            lap_d = '0;
            ovf_d = 1'b0;
        end else begin
            if (counting) begin
                pre_d = tick ? '0 : pre_q + 1'b1;
            end
            if ((state_q == ST_IDLE) && (ev == EV_START)) begin
                pre_d = '0;
            end
            if (tick && (ev != EV_STOP)) begin
                if (cnt_value == BCD_MAX) begin
                    ovf_d = 1'b1;
                end else begin
                    inc_d = 1'b1;
                end
            end
            if ((state_q == ST_RUN) && (ev == EV_LAP)) begin
                lap_d = cnt_value;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pre_q  <= '0;
            lap_q  <= '0;
            disp_q <= '0;
            ovf_q  <= 1'b0;
            inc_q  <= 1'b0;
            clr_q  <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            lap_q  <= lap_d;
            disp_q <= disp_d;
            ovf_q  <= ovf_d;
            inc_q  <= inc_d;
            clr_q  <= clr_d;
        end
    end

    assign cnt_inc    = inc_q;
    assign cnt_clr    = clr_q;
    assign disp_value = disp_q;
    assign overflow   = ovf_q;
    assign running    = counting;
    assign lap_active = (state_q == ST_LAP);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with a behavioural BCD counter attached.
module tb_stopwatch_ctrl;
    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned DEB      = 3;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        BTN_START = 1'b0, BTN_STOP = 1'b0, BTN_LAP = 1'b0, BTN_CLEAR = 1'b0;
    logic [15:0] cnt_value;
    logic        cnt_inc, cnt_clr, running, lap_active, overflow;
    logic [15:0] disp_value;

    logic        load_en = 1'b0;
    logic [15:0] load_val = 16'h0000;
    logic [15:0] model_cnt;

    int compared = 0, mismatched = 0;
    int cyc = 0, base = 0;
    int inc_cnt = 0, clr_cnt = 0, first_inc = -1, last_inc = -1, strobe_err = 0;
    logic prev_inc = 1'b0, prev_clr = 1'b0;

    always #5 CLK = ~CLK;

    stopwatch_ctrl #(.TICK_DIV(TICK_DIV), .DEBOUNCE_CYCLES(DEB)) dut (
        .CLK(CLK), .RST(RST),
        .BTN_START(BTN_START), .BTN_STOP(BTN_STOP), .BTN_LAP(BTN_LAP), .BTN_CLEAR(BTN_CLEAR),
        .cnt_value(cnt_value), .cnt_inc(cnt_inc), .cnt_clr(cnt_clr),
        .disp_value(disp_value), .running(running), .lap_active(lap_active), .overflow(overflow)
    );

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r = v;
        carry = 1'b1;
        for (int d = 0; d < 4; d++) begin
            if (carry) begin
                if (r[d*4 +: 4] == 4'd9) r[d*4 +: 4] = 4'd0;
                else begin
                    r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)          model_cnt <= 16'h0000;
        else if (load_en) model_cnt <= load_val;
        else if (cnt_clr) model_cnt <= 16'h0000;
        else if (cnt_inc) model_cnt <= bcd_inc(model_cnt);
    end
    assign cnt_value = model_cnt;

    // One clock cycle; outputs are sampled 2 time units after the rising edge.
    task automatic step();
        @(posedge CLK);
        #2;
        cyc++;
        if (cnt_inc) begin
            inc_cnt++;
            if (first_inc < 0) first_inc = cyc - base;
            last_inc = cyc - base;
        end
        if (cnt_clr) clr_cnt++;
        if ((cnt_inc && cnt_clr) || (cnt_inc && prev_inc) || (cnt_clr && prev_clr)) strobe_err++;
        prev_inc = cnt_inc;
        prev_clr = cnt_clr;
    endtask

    task automatic adv_to(input int n);
        while (cyc - base < n) step();
    endtask

    task automatic mark();
        base = cyc;
        inc_cnt = 0;
        clr_cnt = 0;
        first_inc = -1;
        last_inc = -1;
    endtask

    task automatic do_reset();
        BTN_START = 1'b0; BTN_STOP = 1'b0; BTN_LAP = 1'b0; BTN_CLEAR = 1'b0;
        RST = 1'b1;
        step();
        step();
        RST = 1'b0;
        step();
    endtask

    task automatic preload(input logic [15:0] v);
        load_en = 1'b1;
        load_val = v;
        step();
        load_en = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        step();
        step();
        compared++;
        if ({cnt_inc, cnt_clr, running, lap_active, overflow} !== 5'b0) begin
            mismatched++;
            $display("FAIL reset_flags: got %05b expected 00000", {cnt_inc, cnt_clr, running, lap_active, overflow});
        end
        compared++;
        if (disp_value !== 16'h0000) begin
            mismatched++;
            $display("FAIL reset_disp: got %h expected 0000", disp_value);
        end
        RST = 1'b0;
        step();
        step();
        compared++;
        if ({cnt_inc, running, overflow} !== 3'b0) begin
            mismatched++;
            $display("FAIL reset_release: got %03b expected 000", {cnt_inc, running, overflow});
        end
    endtask

    task automatic test_glitch();
        do_reset();
        mark();
        BTN_START = 1'b1;
        adv_to(2);
        BTN_START = 1'b0;
        adv_to(15);
        compared++;
        if (running !== 1'b0) begin
            mismatched++;
            $display("FAIL glitch_running: got %0b expected 0", running);
        end
        compared++;
        if (inc_cnt !== 0) begin
            mismatched++;
            $display("FAIL glitch_inc: got %0d incs expected 0", inc_cnt);
        end
    endtask

    task automatic test_run_count();
        do_reset();
        mark();
        BTN_START = 1'b1;
        adv_to(5);
        compared++;
        if (running !== 1'b0) begin
            mismatched++;
            $display("FAIL run_latency_early: got %0b expected 0", running);
        end
        adv_to(6);
        compared++;
        if (running !== 1'b1) begin
            mismatched++;
            $display("FAIL run_latency: got %0b expected 1", running);
        end
        adv_to(10);
        BTN_START = 1'b0;
        adv_to(27);
        compared++;
        if (first_inc !== 10 || last_inc !== 26 || inc_cnt !== 5) begin
            mismatched++;
            $display("FAIL run_inc_timing: got first %0d last %0d n %0d expected 10 26 5", first_inc, last_inc, inc_cnt);
        end
        compared++;
        if (cnt_value !== 16'h0005) begin
            mismatched++;
            $display("FAIL run_count: got %h expected 0005", cnt_value);
        end
        compared++;
        if (disp_value !== 16'h0004) begin
            mismatched++;
            $display("FAIL run_disp: got %h expected 0004", disp_value);
        end
    endtask

    task automatic test_lap();
        do_reset();
        preload(16'h0012);
        mark();
        BTN_START = 1'b1;
        adv_to(1);
        BTN_LAP = 1'b1;
        adv_to(4);
        BTN_START = 1'b0;
        adv_to(5);
        BTN_LAP = 1'b0;
        adv_to(20);
        compared++;
        if (cnt_value !== 16'h0015 || disp_value !== 16'h0012) begin
            mismatched++;
            $display("FAIL lap_freeze: got cnt %h disp %h expected 0015 0012", cnt_value, disp_value);
        end
        compared++;
        if (lap_active !== 1'b1 || running !== 1'b1) begin
            mismatched++;
            $display("FAIL lap_flags: got lap %0b run %0b expected 1 1", lap_active, running);
        end
        BTN_LAP = 1'b1;
        adv_to(24);
        BTN_LAP = 1'b0;
        adv_to(27);
        compared++;
        if (lap_active !== 1'b0 || disp_value !== 16'h0016) begin
            mismatched++;
            $display("FAIL lap_release: got lap %0b disp %h expected 0 0016", lap_active, disp_value);
        end
        adv_to(28);
        compared++;
        if (disp_value !== 16'h0017) begin
            mismatched++;
            $display("FAIL lap_live: got %h expected 0017", disp_value);
        end
    endtask

    task automatic test_stop_lap_same_cycle();
        do_reset();
        mark();
        BTN_START = 1'b1;
        adv_to(4);
        BTN_START = 1'b0;
        adv_to(11);
        BTN_STOP = 1'b1;
        BTN_LAP = 1'b1;
        adv_to(15);
        BTN_STOP = 1'b0;
        BTN_LAP = 1'b0;
        adv_to(17);
        compared++;
        if (running !== 1'b0 || lap_active !== 1'b0) begin
            mismatched++;
            $display("FAIL stoplap_state: got run %0b lap %0b expected 0 0", running, lap_active);
        end
        adv_to(24);
        BTN_START = 1'b1;
        adv_to(28);
        BTN_START = 1'b0;
        compared++;
        if (inc_cnt !== 2 || cnt_value !== 16'h0002) begin
            mismatched++;
            $display("FAIL stoplap_paused: got n %0d cnt %h expected 2 0002", inc_cnt, cnt_value);
        end
        adv_to(31);
        compared++;
        if (inc_cnt !== 3 || last_inc !== 31) begin
            mismatched++;
            $display("FAIL stoplap_residue: got n %0d last %0d expected 3 31", inc_cnt, last_inc);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        mark();
        BTN_START = 1'b1;
        adv_to(4);
        BTN_START = 1'b0;
        adv_to(12);
        BTN_STOP = 1'b1;
        adv_to(16);
        BTN_STOP = 1'b0;
        adv_to(24);
        compared++;
        if (inc_cnt !== 2 || last_inc !== 14 || running !== 1'b0) begin
            mismatched++;
            $display("FAIL stop_on_tick: got n %0d last %0d run %0b expected 2 14 0", inc_cnt, last_inc, running);
        end
        BTN_START = 1'b1;
        adv_to(28);
        BTN_START = 1'b0;
        adv_to(35);
        compared++;
        if (inc_cnt !== 3 || last_inc !== 34) begin
            mismatched++;
            $display("FAIL stop_on_tick_resume: got n %0d last %0d expected 3 34", inc_cnt, last_inc);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        preload(16'h9998);
        mark();
        BTN_START = 1'b1;
        adv_to(4);
        BTN_START = 1'b0;
        adv_to(14);
        compared++;
        if (running !== 1'b0 || overflow !== 1'b1 || cnt_value !== 16'h9999 || inc_cnt !== 1) begin
            mismatched++;
            $display("FAIL ovf_sat: got run %0b ovf %0b cnt %h n %0d expected 0 1 9999 1", running, overflow, cnt_value, inc_cnt);
        end
        adv_to(20);
        BTN_START = 1'b1;
        adv_to(24);
        BTN_START = 1'b0;
        adv_to(32);
        compared++;
        if (running !== 1'b0 || inc_cnt !== 1) begin
            mismatched++;
            $display("FAIL ovf_start_ignored: got run %0b n %0d expected 0 1", running, inc_cnt);
        end
        BTN_CLEAR = 1'b1;
        adv_to(36);
        BTN_CLEAR = 1'b0;
        adv_to(37);
        compared++;
        if (overflow !== 1'b1 || clr_cnt !== 0) begin
            mismatched++;
            $display("FAIL ovf_pre_clear: got ovf %0b clr %0d expected 1 0", overflow, clr_cnt);
        end
        adv_to(38);
        compared++;
        if (cnt_clr !== 1'b1 || overflow !== 1'b0) begin
            mismatched++;
            $display("FAIL ovf_clear: got clr %0b ovf %0b expected 1 0", cnt_clr, overflow);
        end
        adv_to(39);
        compared++;
        if (cnt_value !== 16'h0000 || clr_cnt !== 1 || running !== 1'b0) begin
            mismatched++;
            $display("FAIL ovf_cleared: got cnt %h clr %0d run %0b expected 0000 1 0", cnt_value, clr_cnt, running);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        preload(16'h0012);
        mark();
        BTN_START = 1'b1;
        adv_to(1);
        BTN_LAP = 1'b1;
        adv_to(4);
        BTN_START = 1'b0;
        adv_to(5);
        BTN_LAP = 1'b0;
        adv_to(12);
        compared++;
        if (lap_active !== 1'b1 || disp_value !== 16'h0012) begin
            mismatched++;
            $display("FAIL arst_pre: got lap %0b disp %h expected 1 0012", lap_active, disp_value);
        end
        RST = 1'b1;
        #1;
        compared++;
        if ({cnt_inc, cnt_clr, running, lap_active, overflow} !== 5'b0 || disp_value !== 16'h0000) begin
            mismatched++;
            $display("FAIL arst_async: got flags %05b disp %h expected 00000 0000", {cnt_inc, cnt_clr, running, lap_active, overflow}, disp_value);
        end
        step();
        step();
        RST = 1'b0;
        mark();
        adv_to(20);
        compared++;
        if (inc_cnt !== 0 || clr_cnt !== 0 || running !== 1'b0) begin
            mismatched++;
            $display("FAIL arst_idle: got n %0d clr %0d run %0b expected 0 0 0", inc_cnt, clr_cnt, running);
        end
        BTN_START = 1'b1;
        adv_to(24);
        BTN_START = 1'b0;
        adv_to(31);
        compared++;
        if (inc_cnt !== 1 || last_inc !== 30 || cnt_value !== 16'h0001) begin
            mismatched++;
            $display("FAIL arst_restart: got n %0d last %0d cnt %h expected 1 30 0001", inc_cnt, last_inc, cnt_value);
        end
        compared++;
        if (strobe_err !== 0) begin
            mismatched++;
            $display("FAIL strobe_rules: got %0d violations expected 0", strobe_err);
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_run_count();
        test_lap();
        test_stop_lap_same_cycle();
        test_back_to_back();
        test_overflow();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
